// File: rtl/ita_datapath.sv
// ita_datapath: GF(2^7) Itoh-Tsujii inversion datapath driven by an external control sequencer; optional completion self-check under ITA_DATAPATH_CHECK_EN
module ita_datapath #(
    parameter logic [6:0] POLY = 7'h03
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] a_in,
    input  logic       en,
    input  logic [1:0] n_cascade,
    input  logic [1:0] sel_read,
    input  logic [1:0] sel_write,
    input  logic [1:0] sel_mux1,
    input  logic [1:0] sel_mux2,
`ifdef ITA_DATAPATH_CHECK_EN
    output logic       chk_err,
`endif
    output logic [6:0] result,
    output logic       done,
    output logic       valid,
    output logic       busy,
    output logic [2:0] op_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [6:0] a_reg, acc, rd, x, y, sq1, sq2, sq3, casc, prod;
    logic [6:0] bank [4];
    logic finish;

    function automatic logic [6:0] gmul(input logic [6:0] p, input logic [6:0] q);
        logic [6:0] r, t;
        r = '0;
        t = p;
        for (int i = 0; i < 7; i++) begin
            r = q[i] ? r ^ t : r;
            t = t[6] ? {t[5:0], 1'b0} ^ POLY : {t[5:0], 1'b0};
        end
        return r;
    endfunction

    assign busy = (state == RUN);

    // operand selection, squaring cascade and the single-cycle multiply
    always_comb begin
        rd   = bank[sel_read];
        sq1  = gmul(acc, acc);
        sq2  = gmul(sq1, sq1);
        sq3  = gmul(sq2, sq2);
        casc = n_cascade == 2'd0 ? acc : n_cascade == 2'd1 ? sq1 : n_cascade == 2'd2 ? sq2 : sq3;
        x    = sel_mux1 == 2'd0 ? a_reg : sel_mux1 == 2'd1 ? rd : sel_mux1 == 2'd2 ? acc : 7'h01;
        y    = sel_mux2 == 2'd0 ? a_reg : sel_mux2 == 2'd1 ? casc : sel_mux2 == 2'd2 ? acc : rd;
        prod = gmul(x, y);
    end

    // next state: load restarts from anywhere, an idle control word after at least one op completes
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        if (load) begin
            state_nxt = RUN;
        end else if (state == RUN && !en && op_cnt != 3'd0) begin
            state_nxt = IDLE;
            finish    = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // datapath registers; bank[0] is never written so it stays the constant 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            acc     <= 7'h01;
            bank[0] <= 7'h01;
            bank[1] <= '0;
            bank[2] <= '0;
            bank[3] <= '0;
            op_cnt  <= '0;
            result  <= '0;
            done    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_reg   <= a_in;
                acc     <= 7'h01;
                bank[0] <= 7'h01;
                bank[1] <= '0;
                bank[2] <= '0;
                bank[3] <= '0;
                op_cnt  <= '0;
                valid   <= 1'b0;
            end else if (finish) begin
                result <= acc;
                valid  <= 1'b1;
            end else if (state == RUN && en) begin
                acc    <= prod;
                op_cnt <= op_cnt + {2'b0, op_cnt != 3'd7};
                if (sel_write != 2'd0) bank[sel_write] <= acc;
            end
        end
    end

`ifdef ITA_DATAPATH_CHECK_EN
    // verify the inverse on completion; zero input has no inverse and is never flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      chk_err <= 1'b0;
        else if (finish) chk_err <= (a_reg != 7'h00) && (gmul(acc, a_reg) != 7'h01);
    end
`endif
endmodule

// File: tb/tb_ita_datapath.sv
// tb_ita_datapath: table-driven and scoreboarded checks of the GF(2^7) inversion datapath
module tb_ita_datapath;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] a_in = '0;
    logic       en = 1'b0;
    logic [1:0] n_cascade = '0, sel_read = '0, sel_write = '0, sel_mux1 = '0, sel_mux2 = '0;
    logic [6:0] result;
    logic       done, valid, busy;
    logic [2:0] op_cnt;
`ifdef ITA_DATAPATH_CHECK_EN
    logic       chk_err;
`endif
    int total = 0;
    int bad = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [6:0] a;
        logic [6:0] inv;
    } vec_t;
    vec_t vecs[3];

    ita_datapath dut (
        .clk(clk), .rst_n(rst_n), .load(load), .a_in(a_in), .en(en),
        .n_cascade(n_cascade), .sel_read(sel_read), .sel_write(sel_write),
        .sel_mux1(sel_mux1), .sel_mux2(sel_mux2),
`ifdef ITA_DATAPATH_CHECK_EN
        .chk_err(chk_err),
`endif
        .result(result), .done(done), .valid(valid), .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] mmul(input logic [6:0] a, input logic [6:0] b);
        logic [12:0] p = '0;
        for (int i = 0; i < 7; i++) if (b[i]) p ^= 13'(a) << i;
        for (int i = 12; i >= 7; i--) if (p[i]) p ^= 13'h083 << (i - 7);
        return p[6:0];
    endfunction

    function automatic logic [6:0] minv(input logic [6:0] a);
        for (int v = 1; v < 128; v++) if (mmul(a, 7'(v)) == 7'h01) return 7'(v);
        return 7'h00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] a);
        load = 1'b1;
        a_in = a;
        en   = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic op(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] n, input logic [1:0] rd, input logic [1:0] wr);
        en = 1'b1;
        sel_mux1 = m1;
        sel_mux2 = m2;
        n_cascade = n;
        sel_read = rd;
        sel_write = wr;
        tick();
    endtask

    task automatic chain();
        op(2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        op(2'd0, 2'd1, 2'd1, 2'd0, 2'd0);
        op(2'd0, 2'd1, 2'd1, 2'd0, 2'd0);
        op(2'd2, 2'd1, 2'd3, 2'd0, 2'd0);
        op(2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic finish_run(input string name);
        bit got = 1'b0;
        logic [6:0] e;
        en = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = done;
        end
        e = exp_q.pop_front();
        if (!got) chk({name, " done_timeout"}, done, 1);
        else chk(name, result, e);
    endtask

    initial begin
        vecs[0] = '{7'h02, 7'h41};
        vecs[1] = '{7'h01, 7'h01};
        vecs[2] = '{7'h00, 7'h00};
        #3;
        chk("rst result", result, 0);
        chk("rst done", done, 0);
        chk("rst valid", valid, 0);
        chk("rst busy", busy, 0);
        chk("rst op_cnt", op_cnt, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle busy", busy, 0);

        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].inv);
            do_load(vecs[k].a);
            chk("load busy", busy, 1);
            chk("load valid", valid, 0);
            chain();
            chk("chain op_cnt", op_cnt, 5);
            finish_run($sformatf("vec%0d result", k));
            chk("vec done", done, 1);
            chk("vec valid", valid, 1);
            chk("vec busy", busy, 0);
            chk("vec op_cnt", op_cnt, 5);
`ifdef ITA_DATAPATH_CHECK_EN
            chk("vec chk_err", chk_err, 0);
`endif
            tick();
            chk("vec done pulse", done, 0);
            chk("vec valid hold", valid, 1);
        end

        op(2'd2, 2'd2, 2'd0, 2'd0, 2'd1);
        chk("idle ignore busy", busy, 0);
        chk("idle ignore result", result, 0);
        chk("idle ignore done", done, 0);
        en = 1'b0;

        do_load(7'h02);
        tick();
        tick();
        chk("en0 no ops busy", busy, 1);
        chk("en0 no ops done", done, 0);
        chk("en0 op_cnt", op_cnt, 0);
        exp_q.push_back(7'h41);
        chain();
        finish_run("after en0 result");

        do_load(7'h02);
        op(2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        op(2'd0, 2'd1, 2'd1, 2'd0, 2'd0);
        op(2'd0, 2'd1, 2'd1, 2'd0, 2'd0);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort op_cnt", op_cnt, 0);
        chk("abort result", result, 0);
        chk("abort valid", valid, 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no done", done, 0);
        end
        exp_q.push_back(7'h41);
        do_load(7'h02);
        chain();
        finish_run("post reset result");
        chk("post reset valid", valid, 1);

        do_load(7'h02);
        op(2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        op(2'd0, 2'd1, 2'd1, 2'd0, 2'd0);
        load = 1'b1;
        a_in = 7'h05;
        op(2'd2, 2'd2, 2'd0, 2'd0, 2'd2);
        load = 1'b0;
        chk("reload op_cnt", op_cnt, 0);
        chk("reload valid", valid, 0);
        chk("reload busy", busy, 1);
        exp_q.push_back(7'h01);
        op(2'd2, 2'd3, 2'd0, 2'd0, 2'd0);
        finish_run("reload acc one");

        do_load(7'h02);
        op(2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        op(2'd2, 2'd2, 2'd0, 2'd0, 2'd1);
        for (int i = 0; i < 5; i++) op(2'd3, 2'd2, 2'd0, 2'd0, 2'd0);
        chk("sat op_cnt 7", op_cnt, 7);
        op(2'd3, 2'd2, 2'd0, 2'd0, 2'd0);
        chk("sat op_cnt 8", op_cnt, 7);
        op(2'd1, 2'd2, 2'd0, 2'd1, 2'd0);
        chk("sat op_cnt 9", op_cnt, 7);
        exp_q.push_back(mmul(7'h02, mmul(7'h02, 7'h02)));
        finish_run("bank hold result");
        chk("sat op_cnt done", op_cnt, 7);

        for (int a = 1; a < 128; a++) begin
            exp_q.push_back(minv(7'(a)));
            do_load(7'(a));
            chain();
            finish_run($sformatf("sweep a=%0h", a));
`ifdef ITA_DATAPATH_CHECK_EN
            chk("sweep chk_err", chk_err, 0);
`endif
        end
        chk("sweep product", mmul(result, 7'h7f), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ita_datapath.md
ITA_DATAPATH -- requirements
Module: ita_datapath

Interface
REQ-001 SHALL have parameter POLY, default 7'h03, meaning the low 7 coefficients of the degree-7 reduction polynomial (7'h03 = x^7+x+1).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port LOAD  input  1  start a new inversion with A_IN.
REQ-005 SHALL have port A_IN  input  7  field element to invert, sampled when LOAD=1.
REQ-006 SHALL have port EN  input  1  control word valid; 0 = sequence finished.
REQ-007 SHALL have port N_CASCADE  input  2  number of squarings (0..3) applied to ACC.
REQ-008 SHALL have port SEL_READ  input  2  register-bank read address.
REQ-009 SHALL have port SEL_WRITE  input  2  register-bank write address; 0 = no write.
REQ-010 SHALL have port SEL_MUX1  input  2  multiplier operand X select.
REQ-011 SHALL have port SEL_MUX2  input  2  multiplier operand Y select.
REQ-012 SHALL have ports RESULT output 7 (inverse), DONE output 1 (one-cycle completion pulse), VALID output 1 (RESULT holds a completed inverse), BUSY output 1 (state RUN), OP_CNT output 3 (ops executed this run, saturating at 7).

Function
REQ-013 SHALL be the executing end of the negedge-driven control sequencer: control inputs are sampled on the CLK rising edge only.
REQ-014 SHALL implement states IDLE, RUN; IDLE->RUN on LOAD=1; RUN->IDLE on an edge with EN=0 and OP_CNT>0.
REQ-015 SHALL, on LOAD=1 in any state: A_REG<=A_IN, ACC<=7'h01, BANK[0]<=7'h01, BANK[1..3]<=0, OP_CNT<=0, VALID<=0; LOAD takes priority over EN.
REQ-016 SHALL, in RUN with EN=1 and LOAD=0, execute one op per edge: ACC<=X*Y mod (x^7+POLY), OP_CNT<=min(OP_CNT+1,7).
REQ-017 SHALL select X by SEL_MUX1: 00=A_REG, 01=BANK[SEL_READ], 10=ACC, 11=7'h01.
REQ-018 SHALL select Y by SEL_MUX2: 00=A_REG, 01=ACC^(2^N_CASCADE) (N_CASCADE=0 gives ACC), 10=ACC, 11=BANK[SEL_READ].
REQ-019 SHALL, in the same op, write pre-update ACC to BANK[SEL_WRITE] when SEL_WRITE!=0; BANK[0] is read-only constant 1.
REQ-020 SHALL compute multiply and squaring cascade combinationally within one cycle; op latency 1 cycle.
REQ-021 SHALL, on RUN->IDLE, register RESULT<=ACC, pulse DONE for exactly one cycle, set VALID=1 until next LOAD or reset.
REQ-022 SHALL ignore EN and control inputs in IDLE; EN=0 in RUN with OP_CNT=0 keeps RUN with no DONE.
REQ-023 SHALL give RESULT=0 for A_IN=0 (natural outcome of the sequence, no special case).
REQ-024 SHALL assert BUSY=1 exactly while in RUN.

Reset
REQ-025 SHALL, on RST_N=0, asynchronously force IDLE, RESULT=0, DONE=0, VALID=0, BUSY=0, OP_CNT=0, ACC=7'h01, A_REG=0, BANK[0]=7'h01, BANK[1..3]=0.
REQ-026 SHALL abort any run on reset mid-sequence; no DONE pulse is emitted for the aborted run.

Configuration
REQ-027 SHALL, with macro ITA_DATAPATH_CHECK_EN defined, add output CHK_ERR (1 bit, reset 0), set on completion when A_REG!=0 and RESULT*A_REG!=1 (else cleared), updated with DONE.
REQ-028 SHALL, without ITA_DATAPATH_CHECK_EN, omit CHK_ERR and the check multiplier; all other behaviour identical.

Verification
REQ-029 SHALL cover: LOAD A_IN=7'h02, then 5-op chain {1,2,3,6}+final square, EN=0 -> RESULT=7'h41, DONE one cycle, VALID=1, OP_CNT=5.
REQ-030 SHALL cover: same chain with A_IN=7'h01 -> RESULT=7'h01; with A_IN=7'h00 -> RESULT=7'h00, CHK_ERR=0.
REQ-031 SHALL cover: all 127 nonzero A_IN through the chain -> RESULT*A_IN=1 each, CHK_ERR never set.
REQ-032 SHALL cover: RST_N low after op 3 -> BUSY=0, OP_CNT=0, no DONE; fresh LOAD 7'h02 completes with 7'h41.
REQ-033 SHALL cover: LOAD asserted together with EN=1 mid-run -> ACC=7'h01, OP_CNT=0, VALID=0, op not executed.
REQ-034 SHALL cover: EN=1 held 9 ops -> OP_CNT saturates at 7; SEL_WRITE=0 ops leave BANK unchanged.
